rnn_hstate_argmax: RTL and testbench

- Downstream consumer of the RNN core. It snoops the core's hidden-state write stream: msel=3'b101, maddr={t[10:0],h[5:0]}, mdata_w Q4.16 signed.
- For each timestep it finds the maximum of the 64 hidden values and that value's index.
- Results are buffered in a small FIFO and drained over a valid/ready interface by the host/result logic.

---
 rtl/rnn_pkg.sv | 29 ++
 rtl/rnn_res_fifo.sv | 64 ++++++
 rtl/rnn_hstate_argmax.sv | 200 ++++++++++++++++++++
 tb/tb_rnn_hstate_argmax.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// Shared types and constants for the RNN hidden-state monitor path.
// RNN_HMON_SUM_EN widens the result record with a running sum.
package rnn_pkg;

    localparam logic [2:0] MSEL_HWRITE = 3'b101;
    localparam int H_W    = 20;
    localparam int T_W    = 11;
    localparam int HIDX_W = 6;
    localparam int SUM_W  = 26;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    typedef struct packed {
        logic [T_W-1:0]           t;
        logic [HIDX_W-1:0]        idx;
        logic signed [H_W-1:0]    max;
`ifdef RNN_HMON_SUM_EN
        logic signed [SUM_W-1:0]  sum;
`endif
    } res_t;

    function automatic logic signed [SUM_W-1:0] sext_h(input logic signed [H_W-1:0] v);
        return {{(SUM_W-H_W){v[H_W-1]}}, v};
    endfunction

endpackage

// File: rtl/rnn_res_fifo.sv
// First-word fall-through result FIFO; the head (or the last popped word when
// empty) is always visible on dout. Push and pop may coincide, including when full.
module rnn_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign valid   = !empty;
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? hold_reg : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hold_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                hold_reg   <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rnn_hstate_argmax.sv
// Snoops RNN hidden-state writes and queues per-timestep {t, argmax, max} results.
// Define RNN_HMON_SUM_EN to also accumulate and report the 64-value sum.
module rnn_hstate_argmax
    import rnn_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int N_HIDDEN = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mce,
    input  logic [2:0]              msel,
    input  logic [16:0]             maddr,
    input  logic [H_W-1:0]          mdata_w,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [T_W-1:0]          o_t,
    output logic [HIDX_W-1:0]       o_idx,
    output logic [H_W-1:0]          o_max,
    output logic [SUM_W-1:0]        o_sum,
    output logic                    ovf,
    output logic                    seq_err,
    output logic [T_W-1:0]          n_done
);

    localparam logic [HIDX_W-1:0] H_LAST = HIDX_W'(N_HIDDEN - 1);

    state_t                  state_reg, state_next;
    logic signed [H_W-1:0]   max_reg, max_next;
    logic [HIDX_W-1:0]       idx_reg, idx_next;
    logic [T_W-1:0]          cur_t_reg, cur_t_next;
    logic [HIDX_W-1:0]       exp_h_reg, exp_h_next;
    logic                    seq_err_reg, seq_err_next;
    logic                    pend_valid_reg, pend_valid_next;
    res_t                    pend_data_reg, pend_data_next;
    logic                    ovf_reg;
    logic [T_W-1:0]          n_done_reg;
`ifdef RNN_HMON_SUM_EN
    logic signed [SUM_W-1:0] sum_reg, sum_next;
    logic signed [SUM_W-1:0] sum_acc;
`endif

    logic                    ev;
    logic [T_W-1:0]          ev_t;
    logic [HIDX_W-1:0]       ev_h;
    logic signed [H_W-1:0]   ev_d;
    logic                    take;
    logic signed [H_W-1:0]   cand_max;
    logic [HIDX_W-1:0]       cand_idx;

    res_t                    head;
    logic                    fifo_full;
    logic                    pop;

    assign ev       = mce && (msel == MSEL_HWRITE);
    assign ev_t     = maddr[16:6];
    assign ev_h     = maddr[5:0];
    assign ev_d     = mdata_w;
    // Strict compare: an equal value never displaces the earlier index.
    assign take     = (ev_d > max_reg);
    assign cand_max = take ? ev_d : max_reg;
    assign cand_idx = take ? ev_h : idx_reg;
`ifdef RNN_HMON_SUM_EN
    assign sum_acc  = sum_reg + sext_h(ev_d);
`endif

    always_comb begin
        state_next      = state_reg;
        max_next        = max_reg;
        idx_next        = idx_reg;
        cur_t_next      = cur_t_reg;
        exp_h_next      = exp_h_reg;
        seq_err_next    = seq_err_reg;
        pend_valid_next = 1'b0;
        pend_data_next  = pend_data_reg;
`ifdef RNN_HMON_SUM_EN
        sum_next        = sum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (ev) begin
                    if (ev_h == '0) begin
                        max_next   = ev_d;
                        idx_next   = '0;
                        cur_t_next = ev_t;
                        exp_h_next = HIDX_W'(1);
`ifdef RNN_HMON_SUM_EN
                        sum_next   = sext_h(ev_d);
`endif
                        state_next = ACC;
                    end else begin
                        seq_err_next = 1'b1;
                    end
                end
            end
            ACC: begin
                if (ev) begin
                    if (ev_h == exp_h_reg && ev_t == cur_t_reg) begin
                        max_next = cand_max;
                        idx_next = cand_idx;
`ifdef RNN_HMON_SUM_EN
                        sum_next = sum_acc;
`endif
                        if (ev_h == H_LAST) begin
                            // Result is latched here so the next vector can start at once.
                            pend_valid_next    = 1'b1;
                            pend_data_next.t   = cur_t_reg;
                            pend_data_next.idx = cand_idx;
                            pend_data_next.max = cand_max;
`ifdef RNN_HMON_SUM_EN
                            pend_data_next.sum = sum_acc;
`endif
                            state_next = IDLE;
                        end else begin
                            exp_h_next = exp_h_reg + HIDX_W'(1);
                        end
                    end else if (ev_h == '0) begin
                        seq_err_next = 1'b1;
                        max_next     = ev_d;
                        idx_next     = '0;
                        cur_t_next   = ev_t;
                        exp_h_next   = HIDX_W'(1);
`ifdef RNN_HMON_SUM_EN
                        sum_next     = sext_h(ev_d);
`endif
                    end else begin
                        seq_err_next = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            max_reg        <= '0;
            idx_reg        <= '0;
            cur_t_reg      <= '0;
            exp_h_reg      <= '0;
            seq_err_reg    <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
            ovf_reg        <= 1'b0;
            n_done_reg     <= '0;
`ifdef RNN_HMON_SUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            max_reg        <= max_next;
            idx_reg        <= idx_next;
            cur_t_reg      <= cur_t_next;
            exp_h_reg      <= exp_h_next;
            seq_err_reg    <= seq_err_next;
            pend_valid_reg <= pend_valid_next;
            pend_data_reg  <= pend_data_next;
            if (pend_valid_reg) begin
                n_done_reg <= n_done_reg + T_W'(1);
            end
            if (pend_valid_reg && fifo_full && !pop) begin
                ovf_reg <= 1'b1;
            end
`ifdef RNN_HMON_SUM_EN
            sum_reg        <= sum_next;
`endif
        end
    end

    assign pop = o_valid && o_ready;

    rnn_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(res_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pend_valid_reg),
        .din   (pend_data_reg),
        .pop   (pop),
        .dout  (head),
        .valid (o_valid),
        .full  (fifo_full)
    );

    assign o_t     = head.t;
    assign o_idx   = head.idx;
    assign o_max   = head.max;
`ifdef RNN_HMON_SUM_EN
    assign o_sum   = head.sum;
`else
    assign o_sum   = '0;
`endif
    assign ovf     = ovf_reg;
    assign seq_err = seq_err_reg;
    assign n_done  = n_done_reg;

endmodule

// File: tb/tb_rnn_hstate_argmax.sv
// Directed bench for rnn_hstate_argmax: one task per scenario, inline checks.
module tb_rnn_hstate_argmax;

    logic        clk;
    logic        reset;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic        o_valid;
    logic        o_ready;
    logic [10:0] o_t;
    logic [5:0]  o_idx;
    logic [19:0] o_max;
    logic [25:0] o_sum;
    logic        ovf;
    logic        seq_err;
    logic [10:0] n_done;

    int checks = 0;
    int errors = 0;
    logic [19:0] vec [64];

    rnn_hstate_argmax #(.DEPTH(4), .N_HIDDEN(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .mce     (mce),
        .msel    (msel),
        .maddr   (maddr),
        .mdata_w (mdata_w),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_t     (o_t),
        .o_idx   (o_idx),
        .o_max   (o_max),
        .o_sum   (o_sum),
        .ovf     (ovf),
        .seq_err (seq_err),
        .n_done  (n_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        mce     = 1'b0;
        o_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic write_one(input logic [10:0] t, input logic [5:0] h, input logic [19:0] d);
        @(negedge clk);
        mce     = 1'b1;
        msel    = 3'b101;
        maddr   = {t, h};
        mdata_w = d;
    endtask

    task automatic send_range(input logic [10:0] t, input int lo, input int hi);
        for (int h = lo; h <= hi; h++) begin
            write_one(t, 6'(h), vec[h]);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        mce = 1'b0;
    endtask

    task automatic pop_one();
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mce = 1'b0; msel = 3'b000; maddr = '0; mdata_w = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", o_valid); end
        checks++; if (o_t !== 11'd0) begin errors++; $display("FAIL reset_t got %0h want 0", o_t); end
        checks++; if (o_idx !== 6'd0) begin errors++; $display("FAIL reset_idx got %0h want 0", o_idx); end
        checks++; if (o_max !== 20'd0) begin errors++; $display("FAIL reset_max got %0h want 0", o_max); end
        checks++; if (o_sum !== 26'd0) begin errors++; $display("FAIL reset_sum got %0h want 0", o_sum); end
        checks++; if ({ovf, seq_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {ovf, seq_err}); end
        checks++; if (n_done !== 11'd0) begin errors++; $display("FAIL reset_ndone got %0d want 0", n_done); end
        $display("test_reset done");
    endtask

    task automatic test_inorder();
        for (int h = 0; h < 64; h++) vec[h] = 20'(h * 16);
        // Writes that must be ignored: wrong select, and enable low.
        @(negedge clk); mce = 1'b1; msel = 3'b100; maddr = {11'd5, 6'd5}; mdata_w = 20'h7FFFF;
        @(negedge clk); mce = 1'b0; msel = 3'b101; maddr = {11'd5, 6'd3};
        send_range(11'd5, 0, 63);
        go_idle();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_c1 got %0h want 0", o_valid); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_c2 got %0h want 1", o_valid); end
        checks++; if (o_t !== 11'd5) begin errors++; $display("FAIL inorder_t got %0d want 5", o_t); end
        checks++; if (o_idx !== 6'd63) begin errors++; $display("FAIL inorder_idx got %0d want 63", o_idx); end
        checks++; if (o_max !== 20'h003F0) begin errors++; $display("FAIL inorder_max got %0h want 003f0", o_max); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL ignored_writes seq_err got %0h want 0", seq_err); end
        checks++; if (n_done !== 11'd1) begin errors++; $display("FAIL inorder_ndone got %0d want 1", n_done); end
        pop_one();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pop_empty got %0h want 0", o_valid); end
        checks++; if (o_t !== 11'd5 || o_max !== 20'h003F0) begin errors++; $display("FAIL empty_hold got t=%0d max=%0h want t=5 max=003f0", o_t, o_max); end
        // o_ready with an empty FIFO must not disturb anything.
        pop_one();
        checks++; if (o_valid !== 1'b0 || o_idx !== 6'd63) begin errors++; $display("FAIL empty_ready got v=%0h idx=%0d want v=0 idx=63", o_valid, o_idx); end
        $display("test_inorder done t=%0d idx=%0d max=%0h", o_t, o_idx, o_max);
    endtask

    task automatic test_tie();
        for (int h = 0; h < 64; h++) vec[h] = 20'hF0000;
        vec[7]  = 20'h10000;
        vec[40] = 20'h10000;
        send_range(11'd6, 0, 63);
        go_idle();
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_t !== 11'd6) begin errors++; $display("FAIL tie_head got v=%0h t=%0d want v=1 t=6", o_valid, o_t); end
        checks++; if (o_idx !== 6'd7) begin errors++; $display("FAIL tie_idx got %0d want 7", o_idx); end
        checks++; if (o_max !== 20'h10000) begin errors++; $display("FAIL tie_max got %0h want 10000", o_max); end
        pop_one();
        $display("test_tie done idx=%0d max=%0h", o_idx, o_max);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int h = 0; h < 64; h++) vec[h] = (h == k + 10) ? 20'd100 : 20'd0;
            send_range(11'(k), 0, 63);
        end
        go_idle();
        @(negedge clk);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %0h want 1", ovf); end
        checks++; if (n_done !== 11'd5) begin errors++; $display("FAIL b2b_ndone got %0d want 5", n_done); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL b2b_seq_err got %0h want 0", seq_err); end
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_t !== 11'(i) || o_idx !== 6'(i + 10) || o_max !== 20'd100) begin
                errors++;
                $display("FAIL b2b_pop%0d got v=%0h t=%0d idx=%0d max=%0h want v=1 t=%0d idx=%0d max=64", i, o_valid, o_t, o_idx, o_max, i, i + 10);
            end
            @(negedge clk);
        end
        o_ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0h want 0", o_valid); end
        $display("test_back_to_back done ndone=%0d ovf=%0h", n_done, ovf);
    endtask

    task automatic test_seq_err();
        do_reset();
        write_one(11'd8, 6'd0, 20'd1);
        write_one(11'd8, 6'd1, 20'd2);
        write_one(11'd8, 6'd2, 20'd3);
        write_one(11'd8, 6'd4, 20'd4);
        go_idle();
        @(negedge clk);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL gap_seq_err got %0h want 1", seq_err); end
        checks++; if (o_valid !== 1'b0 || n_done !== 11'd0) begin errors++; $display("FAIL gap_nopush got v=%0h n=%0d want v=0 n=0", o_valid, n_done); end
        for (int h = 0; h < 64; h++) vec[h] = 20'(h * 16);
        send_range(11'd9, 0, 63);
        go_idle();
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_t !== 11'd9 || o_idx !== 6'd63) begin errors++; $display("FAIL clean_after_err got v=%0h t=%0d idx=%0d want v=1 t=9 idx=63", o_valid, o_t, o_idx); end
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky got %0h want 1", seq_err); end
        pop_one();
        // Restart: h==0 mid-vector abandons t=10 and starts t=11 from that write.
        for (int h = 0; h < 64; h++) vec[h] = (h == 20) ? 20'd5 : 20'hFFFFF;
        send_range(11'd10, 0, 5);
        send_range(11'd11, 0, 63);
        go_idle();
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_t !== 11'd11 || o_idx !== 6'd20 || o_max !== 20'd5) begin errors++; $display("FAIL restart got v=%0h t=%0d idx=%0d max=%0h want v=1 t=11 idx=20 max=5", o_valid, o_t, o_idx, o_max); end
        pop_one();
        checks++; if (o_valid !== 1'b0 || n_done !== 11'd2) begin errors++; $display("FAIL restart_single got v=%0h n=%0d want v=0 n=2", o_valid, n_done); end
        // t changing mid-vector.
        do_reset();
        send_range(11'd12, 0, 10);
        write_one(11'd13, 6'd11, 20'd0);
        go_idle();
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL t_change got %0h want 1", seq_err); end
        $display("test_seq_err done seq_err=%0h ndone=%0d", seq_err, n_done);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int h = 0; h < 64; h++) vec[h] = 20'(h * 16);
        send_range(11'd2, 0, 30);
        @(negedge clk);
        mce   = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send_range(11'd3, 0, 63);
        go_idle();
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_t !== 11'd3) begin errors++; $display("FAIL rstmid_head got v=%0h t=%0d want v=1 t=3", o_valid, o_t); end
        checks++; if ({ovf, seq_err} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b want 00", {ovf, seq_err}); end
        checks++; if (n_done !== 11'd1) begin errors++; $display("FAIL rstmid_ndone got %0d want 1", n_done); end
        pop_one();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_only got %0h want 0", o_valid); end
        $display("test_reset_mid done t=%0d", o_t);
    endtask

    task automatic test_sum();
        logic [25:0] exp_pos;
        logic [25:0] exp_neg;
`ifdef RNN_HMON_SUM_EN
        exp_pos = 26'h0400000;
        exp_neg = 26'h3C00000;
`else
        exp_pos = 26'h0;
        exp_neg = 26'h0;
`endif
        do_reset();
        for (int h = 0; h < 64; h++) vec[h] = 20'h10000;
        send_range(11'd20, 0, 63);
        go_idle();
        @(negedge clk);
        checks++; if (o_idx !== 6'd0 || o_max !== 20'h10000) begin errors++; $display("FAIL pos_sat got idx=%0d max=%0h want idx=0 max=10000", o_idx, o_max); end
        checks++; if (o_sum !== exp_pos) begin errors++; $display("FAIL sum_pos got %0h want %0h", o_sum, exp_pos); end
        pop_one();
        for (int h = 0; h < 64; h++) vec[h] = 20'hF0000;
        send_range(11'd21, 0, 63);
        go_idle();
        @(negedge clk);
        checks++; if (o_t !== 11'd21 || o_max !== 20'hF0000) begin errors++; $display("FAIL neg_sat got t=%0d max=%0h want t=21 max=f0000", o_t, o_max); end
        checks++; if (o_sum !== exp_neg) begin errors++; $display("FAIL sum_neg got %0h want %0h", o_sum, exp_neg); end
        pop_one();
        $display("test_sum done sum=%0h", o_sum);
    endtask

    initial begin
        test_reset();
        test_inorder();
        test_tie();
        test_back_to_back();
        test_seq_err();
        test_reset_mid();
        test_sum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
